// File: rtl/kianv_clint_pkg.sv
// kianv_clint_pkg
//   Shared definitions for the core-local interruptor (CLINT):
//   - register byte offsets inside the 16-bit CLINT window
//   - reset value of mtimecmp/stimecmp
//   - bus FSM state type
//   - byte-strobe merge helper and word-offset match helper
//   Optional feature macro: KIANV_CLINT_SUPERVISOR_EN (ssip / stimecmp registers).
package kianv_clint_pkg;

  localparam int CLINT_ADDR_W = 16;

  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;
  localparam logic [15:0] CLINT_SSIP_OFF        = 16'hC000;
  localparam logic [15:0] CLINT_STIMECMP_LO_OFF = 16'hD000;
  localparam logic [15:0] CLINT_STIMECMP_HI_OFF = 16'hD004;

  localparam logic [63:0] CLINT_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Word match: byte lane bits [1:0] never take part in decode.
  function automatic logic off_hit(input logic [CLINT_ADDR_W-1:0] addr,
                                   input logic [CLINT_ADDR_W-1:0] off);
    return addr[CLINT_ADDR_W-1:2] == off[CLINT_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/kianv_clint_tick_gen.sv
// kianv_clint_tick_gen
//   Prescaler for the machine timer. Counts 0..DIV-1 and asserts tick
//   while the count equals DIV-1; the count then wraps to 0. With DIV=1
//   the counter stays at 0 and tick is asserted every cycle.
// Ports
//   clk    in  clock
//   resetn in  synchronous reset, active-low (count returns to 0)
//   tick   out one-cycle strobe, once every DIV cycles
module kianv_clint_tick_gen #(
  parameter int unsigned DIV = 50
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kianv_clint.sv
// kianv_clint
//   Core-local interruptor for the rv32ima SoC: memory-mapped msip,
//   64-bit mtime and mtimecmp, driving the machine software (IRQ3) and
//   machine timer (IRQ7) interrupt lines.
//   Optional macro KIANV_CLINT_SUPERVISOR_EN adds ssip (0xC000) and
//   stimecmp (0xD000/0xD004) with ssip_irq/stip_irq outputs; without it
//   those offsets decode as unmapped and the ports do not exist.
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   mem_valid/mem_ready  bus request / one-cycle completion pulse
//   mem_addr             16-bit byte offset in the CLINT window
//   mem_wstrb/mem_wdata  byte write enables (0 = read) / write data
//   mem_rdata            read data, zero whenever mem_ready is low
//   msip_irq, mtip_irq   machine software / timer interrupt
//   mtime                current 64-bit timer value
//   ssip_irq, stip_irq   supervisor software / timer interrupt (optional)
//   dbg_state            bus FSM state (0 = IDLE, 1 = ACK)
//
// Handshake: the master raises mem_valid with stable addr/wstrb/wdata
// and holds them until it sees mem_ready. In IDLE a valid request is
// accepted on the next clock edge (any write is committed on that same
// edge) and the FSM moves to ACK, where mem_ready is high for exactly one
// cycle with the registered read data. ACK always returns to IDLE, so a
// valid still high in the following cycle is a new access.
module kianv_clint
  import kianv_clint_pkg::*;
#(
  parameter int unsigned SYSTEM_CLK = 50_000_000,
  parameter int unsigned TIMER_HZ   = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [15:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        msip_irq,
  output logic        mtip_irq,
  output logic [63:0] mtime,
`ifdef KIANV_CLINT_SUPERVISOR_EN
  output logic        ssip_irq,
  output logic        stip_irq,
`endif
  output logic        dbg_state
);

  localparam int unsigned DIV = SYSTEM_CLK / TIMER_HZ;

  logic tick;

  kianv_clint_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .tick   (tick)
  );

  // Byte-lane bits are not decoded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

  bus_state_e  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        msip_q, msip_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q, mtip_d;
`ifdef KIANV_CLINT_SUPERVISOR_EN
  logic        ssip_q, ssip_d;
  logic [63:0] stimecmp_q, stimecmp_d;
  logic        stip_q, stip_d;
`endif

  logic accept;
  logic wr_en;
  logic [31:0] read_val;

  logic hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mtime_lo, hit_mtime_hi;
  assign hit_msip     = off_hit(mem_addr, CLINT_MSIP_OFF);
  assign hit_cmp_lo   = off_hit(mem_addr, CLINT_MTIMECMP_LO_OFF);
  assign hit_cmp_hi   = off_hit(mem_addr, CLINT_MTIMECMP_HI_OFF);
  assign hit_mtime_lo = off_hit(mem_addr, CLINT_MTIME_LO_OFF);
  assign hit_mtime_hi = off_hit(mem_addr, CLINT_MTIME_HI_OFF);
`ifdef KIANV_CLINT_SUPERVISOR_EN
  logic hit_ssip, hit_scmp_lo, hit_scmp_hi;
  assign hit_ssip    = off_hit(mem_addr, CLINT_SSIP_OFF);
  assign hit_scmp_lo = off_hit(mem_addr, CLINT_STIMECMP_LO_OFF);
  assign hit_scmp_hi = off_hit(mem_addr, CLINT_STIMECMP_HI_OFF);
`endif

  assign accept = (state_q == BUS_IDLE) && mem_valid;
  assign wr_en  = accept && (mem_wstrb != 4'b0000);

  // Read mux; anything not decoded reads as zero.
  always_comb begin
    read_val = 32'h0;
    if (hit_msip)          read_val = {31'b0, msip_q};
    else if (hit_cmp_lo)   read_val = mtimecmp_q[31:0];
    else if (hit_cmp_hi)   read_val = mtimecmp_q[63:32];
    else if (hit_mtime_lo) read_val = mtime_q[31:0];
    else if (hit_mtime_hi) read_val = mtime_q[63:32];
`ifdef KIANV_CLINT_SUPERVISOR_EN
    else if (hit_ssip)     read_val = {31'b0, ssip_q};
    else if (hit_scmp_lo)  read_val = stimecmp_q[31:0];
    else if (hit_scmp_hi)  read_val = stimecmp_q[63:32];
`endif
  end

  // Bus FSM next state and response data.
  always_comb begin
    state_d = state_q;
    rdata_d = 32'h0;
    case (state_q)
      BUS_IDLE: begin
        if (mem_valid) begin
          state_d = BUS_ACK;
          if (mem_wstrb == 4'b0000) rdata_d = read_val;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  // Register updates.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;

    if (wr_en && hit_msip && mem_wstrb[0]) msip_d = mem_wdata[0];

    if (wr_en && hit_cmp_lo)
      mtimecmp_d[31:0] = apply_wstrb(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
    if (wr_en && hit_cmp_hi)
      mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], mem_wdata, mem_wstrb);

    // A bus write to either half wins over the tick; the dropped tick's
    // carry is never propagated into the other half.
    if (wr_en && hit_mtime_lo)
      mtime_d[31:0] = apply_wstrb(mtime_q[31:0], mem_wdata, mem_wstrb);
    else if (wr_en && hit_mtime_hi)
      mtime_d[63:32] = apply_wstrb(mtime_q[63:32], mem_wdata, mem_wstrb);
    else if (tick)
      mtime_d = mtime_q + 64'd1;

    // Compare the current registers, so the irq follows one cycle later.
    mtip_d = (mtime_q >= mtimecmp_q);
  end

`ifdef KIANV_CLINT_SUPERVISOR_EN
  always_comb begin
    ssip_d     = ssip_q;
    stimecmp_d = stimecmp_q;
    if (wr_en && hit_ssip && mem_wstrb[0]) ssip_d = mem_wdata[0];
    if (wr_en && hit_scmp_lo)
      stimecmp_d[31:0] = apply_wstrb(stimecmp_q[31:0], mem_wdata, mem_wstrb);
    if (wr_en && hit_scmp_hi)
      stimecmp_d[63:32] = apply_wstrb(stimecmp_q[63:32], mem_wdata, mem_wstrb);
    stip_d = (mtime_q >= stimecmp_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= BUS_IDLE;
      rdata_q    <= 32'h0;
      msip_q     <= 1'b0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= CLINT_MTIMECMP_RESET;
      mtip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= mtip_d;
    end
  end

`ifdef KIANV_CLINT_SUPERVISOR_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ssip_q     <= 1'b0;
      stimecmp_q <= CLINT_MTIMECMP_RESET;
      stip_q     <= 1'b0;
    end else begin
      ssip_q     <= ssip_d;
      stimecmp_q <= stimecmp_d;
      stip_q     <= stip_d;
    end
  end

  assign ssip_irq = ssip_q;
  assign stip_irq = stip_q;
`endif

  assign mem_ready = (state_q == BUS_ACK);
  assign mem_rdata = rdata_q;
  assign msip_irq  = msip_q;
  assign mtip_irq  = mtip_q;
  assign mtime     = mtime_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kianv_clint.sv
// tb_kianv_clint
//   Self-checking bench for kianv_clint with DIV=2. A reference model
//   tracks msip, mtime, mtimecmp and the irqs from the register-map
//   rules; every cycle the DUT outputs are compared against it and read
//   responses are taken from an expected queue. Directed steps are
//   followed by a randomized phase.
module tb_kianv_clint;

  localparam int unsigned SYS_CLK = 2;
  localparam int unsigned TMR_HZ  = 1;
  localparam int          DIV     = 2;

  localparam logic [15:0] ADDR_TBL [10] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                                            16'hBFFC, 16'hC000, 16'hD000, 16'hD004,
                                            16'h1234, 16'h4006};

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        msip_irq;
  logic        mtip_irq;
  logic [63:0] mtime;
  logic        dbg_state;
`ifdef KIANV_CLINT_SUPERVISOR_EN
  logic        ssip_irq;
  logic        stip_irq;
`endif

  kianv_clint #(
    .SYSTEM_CLK (SYS_CLK),
    .TIMER_HZ   (TMR_HZ)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .msip_irq  (msip_irq),
    .mtip_irq  (mtip_irq),
    .mtime     (mtime),
`ifdef KIANV_CLINT_SUPERVISOR_EN
    .ssip_irq  (ssip_irq),
    .stip_irq  (stip_irq),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_mtip, m_ready, m_rd;
  int          m_phase;
`ifdef KIANV_CLINT_SUPERVISOR_EN
  logic [63:0] m_scmp;
  logic        m_ssip, m_stip;
`endif
  logic [31:0] exp_q[$];

  wire        m_tick = (m_phase == DIV - 1);
  wire        m_acc  = mem_valid && !m_ready;
  wire        m_wr   = m_acc && (mem_wstrb != 4'b0000);
  wire [13:0] m_word = mem_addr[15:2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    case (a[15:2])
      14'h0000: return {31'b0, m_msip};
      14'h1000: return m_cmp[31:0];
      14'h1001: return m_cmp[63:32];
      14'h2FFE: return m_mtime[31:0];
      14'h2FFF: return m_mtime[63:32];
`ifdef KIANV_CLINT_SUPERVISOR_EN
      14'h3000: return {31'b0, m_ssip};
      14'h3400: return m_scmp[31:0];
      14'h3401: return m_scmp[63:32];
`endif
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_mtime <= 64'h0;
      m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip  <= 1'b0;
      m_mtip  <= 1'b0;
      m_ready <= 1'b0;
      m_rd    <= 1'b0;
      m_phase <= 0;
`ifdef KIANV_CLINT_SUPERVISOR_EN
      m_scmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      m_ssip  <= 1'b0;
      m_stip  <= 1'b0;
`endif
      exp_q.delete();
    end else begin
      m_ready <= m_acc;
      m_rd    <= m_acc && !m_wr;
      if (m_acc && !m_wr) exp_q.push_back(model_read(mem_addr));
      m_phase <= m_tick ? 0 : m_phase + 1;
      m_mtip  <= (m_mtime >= m_cmp);
      if (m_wr && m_word == 14'h2FFE)
        m_mtime <= {m_mtime[63:32], merge(m_mtime[31:0], mem_wdata, mem_wstrb)};
      else if (m_wr && m_word == 14'h2FFF)
        m_mtime <= {merge(m_mtime[63:32], mem_wdata, mem_wstrb), m_mtime[31:0]};
      else if (m_tick)
        m_mtime <= m_mtime + 64'd1;
      if (m_wr && m_word == 14'h1000) m_cmp[31:0]  <= merge(m_cmp[31:0], mem_wdata, mem_wstrb);
      if (m_wr && m_word == 14'h1001) m_cmp[63:32] <= merge(m_cmp[63:32], mem_wdata, mem_wstrb);
      if (m_wr && m_word == 14'h0000 && mem_wstrb[0]) m_msip <= mem_wdata[0];
`ifdef KIANV_CLINT_SUPERVISOR_EN
      m_stip <= (m_mtime >= m_scmp);
      if (m_wr && m_word == 14'h3400) m_scmp[31:0]  <= merge(m_scmp[31:0], mem_wdata, mem_wstrb);
      if (m_wr && m_word == 14'h3401) m_scmp[63:32] <= merge(m_scmp[63:32], mem_wdata, mem_wstrb);
      if (m_wr && m_word == 14'h3000 && mem_wstrb[0]) m_ssip <= mem_wdata[0];
`endif
    end
  end

  // ---------------- checking ----------------
  int tests;
  int fails;
  bit chk_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare all outputs with the model.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("mem_ready", 64'(mem_ready), 64'(m_ready));
      check("dbg_state", 64'(dbg_state), 64'(m_ready));
      if (m_ready && m_rd && exp_q.size() > 0) check("rdata", 64'(mem_rdata), 64'(exp_q.pop_front()));
      else if (!m_ready) check("rdata_idle", 64'(mem_rdata), 64'd0);
      check("mtime", mtime, m_mtime);
      check("msip_irq", 64'(msip_irq), 64'(m_msip));
      check("mtip_irq", 64'(mtip_irq), 64'(m_mtip));
`ifdef KIANV_CLINT_SUPERVISOR_EN
      check("ssip_irq", 64'(ssip_irq), 64'(m_ssip));
      check("stip_irq", 64'(stip_irq), 64'(m_stip));
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_access(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d,
                            input bit align_tick, output logic [31:0] rd);
    int n;
    step();
    n = 0;
    while (align_tick && m_phase != DIV - 1 && n < 8) begin
      step();
      n++;
    end
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wstrb = s;
    mem_wdata = d;
    n = 0;
    do begin
      step();
      n++;
    end while (mem_ready !== 1'b1 && n < 10);
    check("ack_seen", 64'(mem_ready), 64'd1);
    rd        = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] dummy;
    bus_access(a, s, d, 1'b0, dummy);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] rd);
    bus_access(a, 4'b0000, 32'h0, 1'b0, rd);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] d;
    logic [15:0] a;
    logic [3:0]  s;
    int          n;
    int          pulses;

    tests = 0; fails = 0; chk_en = 0;
    resetn = 1'b0; mem_valid = 1'b0; mem_addr = 16'h0; mem_wstrb = 4'b0; mem_wdata = 32'h0;
    do_reset();
    chk_en = 1;

    // Reset state, then 10 idle cycles: mtime advances once per DIV cycles.
    check("rst_mtime", mtime, 64'd0);
    check("rst_ready", 64'(mem_ready), 64'd0);
    check("rst_rdata", 64'(mem_rdata), 64'd0);
    repeat (10) step();
    check("idle_msip", 64'(msip_irq), 64'd0);
    check("idle_mtip", 64'(mtip_irq), 64'd0);
    check("idle_mtime", mtime, 64'd5);
    bus_read(16'h4000, rd); check("cmp_lo_rst", 64'(rd), 64'hFFFF_FFFF);
    bus_read(16'h4004, rd); check("cmp_hi_rst", 64'(rd), 64'hFFFF_FFFF);

    // mtip rises once mtime reaches 5, falls after mtimecmp hi = 1.
    bus_write(16'hBFFC, 4'hF, 32'h0);
    bus_write(16'hBFF8, 4'hF, 32'h0);
    bus_write(16'h4004, 4'hF, 32'h0);
    bus_write(16'h4000, 4'hF, 32'h5);
    n = 0;
    while (mtip_irq !== 1'b1 && n < 60) begin step(); n++; end
    check("mtip_rise", 64'(mtip_irq), 64'd1);
    check("mtip_rise_at", 64'(mtime >= 64'd5), 64'd1);
    bus_write(16'h4004, 4'hF, 32'h1);
    step();
    check("mtip_fall", 64'(mtip_irq), 64'd0);

    // msip: only bit 0 is implemented.
    bus_write(16'h0000, 4'hF, 32'hFFFF_FFFF);
    check("msip_set", 64'(msip_irq), 64'd1);
    bus_read(16'h0000, rd); check("msip_read", 64'(rd), 64'h1);
    bus_write(16'h0000, 4'hF, 32'h0);
    check("msip_clr", 64'(msip_irq), 64'd0);

    // mtime lo write on a tick edge: tick dropped, no carry; next tick wraps.
    bus_write(16'hBFFC, 4'hF, 32'h12);
    bus_access(16'hBFF8, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
    check("mtime_lo_wr", mtime, 64'h0000_0012_FFFF_FFFF);
    step(); step();
    check("mtime_wrap", mtime, 64'h0000_0013_0000_0000);
    bus_read(16'hBFFC, rd); check("mtime_hi_rd", 64'(rd), 64'h13);

    // Partial write into reset mtimecmp lo; unmapped read.
    do_reset();
    bus_write(16'h4000, 4'b0010, 32'hAABB_CCDD);
    bus_read(16'h4000, rd); check("cmp_lo_strb", 64'(rd), 64'hFFFF_CCFF);
    bus_read(16'h1234, rd); check("unmapped_rd", 64'(rd), 64'd0);
    pulses = 0;
    repeat (5) begin step(); if (mem_ready === 1'b1) pulses++; end
    check("unmapped_one_ack", 64'(pulses), 64'd0);

`ifdef KIANV_CLINT_SUPERVISOR_EN
    bus_write(16'hD004, 4'hF, 32'h0);
    bus_write(16'hD000, 4'hF, 32'h3);
    n = 0;
    while (stip_irq !== 1'b1 && n < 60) begin step(); n++; end
    check("stip_rise", 64'(stip_irq), 64'd1);
    check("stip_mtip_low", 64'(mtip_irq), 64'd0);
    bus_write(16'hC000, 4'h1, 32'h1);
    check("ssip_set", 64'(ssip_irq), 64'd1);
`else
    bus_write(16'hD000, 4'hF, 32'h3);
    bus_read(16'hD000, rd); check("d000_unmapped", 64'(rd), 64'd0);
`endif

    // Reset asserted on the edge that would commit a write.
    step();
    mem_valid = 1'b1; mem_addr = 16'h0000; mem_wstrb = 4'h1; mem_wdata = 32'h1; resetn = 1'b0;
    step();
    check("rst_mid_ready", 64'(mem_ready), 64'd0);
    check("rst_mid_msip", 64'(msip_irq), 64'd0);
    mem_valid = 1'b0; mem_wstrb = 4'h0; resetn = 1'b1;
    step();
    check("rst_mid_noack", 64'(mem_ready), 64'd0);

    // Randomized accesses; the per-cycle checks and the read queue do the work.
    for (int i = 0; i < 300; i++) begin
      a = ADDR_TBL[$urandom_range(0, 9)];
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (a == 16'h4000 || a == 16'hD000) begin
        if ($urandom_range(0, 1) == 1) d = m_mtime[31:0] + $urandom_range(0, 12);
      end else if (a == 16'h4004 || a == 16'hD004) begin
        if ($urandom_range(0, 2) != 0) d = m_mtime[63:32];
      end else if (a == 16'hBFFC) begin
        if ($urandom_range(0, 1) == 1) d = m_mtime[63:32];
      end
      bus_access(a, s, d, ($urandom_range(0, 3) == 0), rd);
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
